// File: rtl/ctrl_pkg.sv
// Shared encodings for the decode/issue controller: cmd codes, ALU ops,
// instruction classes, FSM states and the decoded control bundle.
package ctrl_pkg;

   // cmd = funct[4:1]
   localparam logic [3:0] FMULT    = 4'b0000;
   localparam logic [3:0] FSUB     = 4'b0010;
   localparam logic [3:0] FADD     = 4'b0100;
   localparam logic [3:0] FAVERAGE = 4'b1000;
   localparam logic [3:0] FSTR     = 4'b1010;
   localparam logic [3:0] FSTR_ONE = 4'b1011;
   localparam logic [3:0] FLOAD    = 4'b1100;
   localparam logic [3:0] FPIC     = 4'b1110;
   localparam logic [3:0] FB       = 4'b1111;

   localparam logic [1:0] OPDATA   = 2'b00;
   localparam logic [1:0] OPMEM    = 2'b01;
   localparam logic [1:0] OPBRANCH = 2'b10;

   typedef enum logic [3:0] {
      ADD    = 4'd0,
      SUB    = 4'd1,
      MULT   = 4'd2,
      BUFFER = 4'd3,
      AV     = 4'd4
   } alu_t;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MULT_WAIT = 2'd1,
      AVG_SEQ   = 2'd2
   } state_t;

   // Single-cycle view of one decoded instruction
   typedef struct packed {
      logic alusrc;
      alu_t alu;
      logic memtoreg;
      logic regwrite;
      logic plusone;
      logic branch;
      logic illegal;
      logic is_mult;
      logic is_avg;
   } ctrl_bundle_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational cmd/opcode decode into the control bundle plus the
// D-stage source selects. Undefined cmds decode to a safe bubble.
module ctrl_decode
   import ctrl_pkg::*;
(
   input  logic [3:0]   cmd,
   input  logic [1:0]   opcode,
   output ctrl_bundle_t bundle,
   output logic [1:0]   regsrc,
   output logic [1:0]   immsrc
);

   // Map cmd to ALU op, write enables and immediate select
   always_comb begin
      bundle        = '0;
      bundle.alu    = BUFFER;
      bundle.alusrc = opcode[0];
      bundle.branch = (opcode == OPBRANCH);
      regsrc        = '0;
      immsrc        = '0;
      unique case (cmd)
         FADD: begin
            bundle.alu      = ADD;
            bundle.regwrite = 1'b1;
         end
         FSUB: begin
            bundle.alu      = SUB;
            bundle.regwrite = 1'b1;
         end
         FMULT: begin
            bundle.alu      = MULT;
            bundle.regwrite = 1'b1;
            bundle.is_mult  = 1'b1;
         end
         FAVERAGE: begin
            bundle.alu      = AV;
            bundle.regwrite = 1'b1;
            bundle.is_avg   = 1'b1;
         end
         FSTR: begin
            immsrc[0] = 1'b1;
         end
         FSTR_ONE: begin
            bundle.plusone  = 1'b1;
            bundle.regwrite = 1'b1;
         end
         FLOAD: begin
            bundle.memtoreg = 1'b1;
            bundle.regwrite = 1'b1;
            immsrc[0]       = 1'b1;
         end
         FPIC: begin
            bundle.regwrite = 1'b0;
         end
         FB: begin
            bundle.regwrite = 1'b1;
            immsrc[1]       = 1'b1;
         end
         default: begin
            // Undefined cmd: no side effects may leak into E
            bundle.illegal = 1'b1;
            bundle.branch  = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/ctrl_unit_mc.sv
// Decode/issue controller: decodes in D, registers the E-stage bundle and
// sequences multi-cycle MULT and per-channel AVERAGE micro-ops.
// Optional macro CTRL_ILLEGAL_TRAP_EN enables the sticky IllegalTrap flag.
module ctrl_unit_mc
   import ctrl_pkg::*;
#(
   parameter int MULT_LAT = 3,
   parameter int NUM_CH   = 3,
   parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   parameter int ALU_W    = 4
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValidD,
   input  logic [5:0]       funct,
   input  logic [1:0]       opcode,
   input  logic             FlushE,
   output logic             StallD,
   output logic [1:0]       RegSrcD,
   output logic [1:0]       ImmSrcD,
   output logic             IllegalD,
   output logic             ValidE,
   output logic             ALUSrcE,
   output logic [ALU_W-1:0] ALUControlE,
   output logic             MemToRegE,
   output logic             RegWriteE,
   output logic             PlusOneE,
   output logic             BranchE,
   output logic [CH_W-1:0]  ChannelE,
   output logic             LastE,
   output logic             IllegalTrap
);

   localparam int MAXC  = (MULT_LAT > NUM_CH) ? MULT_LAT : NUM_CH;
   localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

   state_t       state;
   logic [CNT_W-1:0] cnt;
   ctrl_bundle_t dec;
   logic         unused_funct;

   assign unused_funct = ^{funct[5], funct[0]};

   ctrl_decode u_decode (
      .cmd    (funct[4:1]),
      .opcode (opcode),
      .bundle (dec),
      .regsrc (RegSrcD),
      .immsrc (ImmSrcD)
   );

   assign IllegalD = InstrValidD & dec.illegal;
   assign StallD   = (state != IDLE);

   // FSM, remaining-cycle counter and E-stage bundle register.
   // Reset, flush and an idle cycle without an instruction all produce the
   // same bubble, so they share one branch.
   always_ff @(posedge clk) begin
      if (reset || FlushE || (state == IDLE && !InstrValidD)) begin
         state       <= IDLE;
         cnt         <= '0;
         ValidE      <= 1'b0;
         ALUSrcE     <= 1'b0;
         ALUControlE <= ALU_W'(BUFFER);
         MemToRegE   <= 1'b0;
         RegWriteE   <= 1'b0;
         PlusOneE    <= 1'b0;
         BranchE     <= 1'b0;
         ChannelE    <= '0;
         LastE       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               ValidE      <= 1'b1;
               ALUSrcE     <= dec.alusrc;
               ALUControlE <= ALU_W'(dec.alu);
               MemToRegE   <= dec.memtoreg;
               PlusOneE    <= dec.plusone;
               BranchE     <= dec.branch;
               ChannelE    <= '0;
               if (dec.is_mult && MULT_LAT > 1) begin
                  RegWriteE <= 1'b0;
                  LastE     <= 1'b0;
                  cnt       <= CNT_W'(MULT_LAT - 2);
                  state     <= MULT_WAIT;
               end else if (dec.is_avg && NUM_CH > 1) begin
                  RegWriteE <= 1'b0;
                  LastE     <= 1'b0;
                  cnt       <= CNT_W'(NUM_CH - 2);
                  state     <= AVG_SEQ;
               end else begin
                  RegWriteE <= dec.regwrite;
                  LastE     <= 1'b1;
               end
            end
            MULT_WAIT: begin
               if (cnt == '0) begin
                  RegWriteE <= 1'b1;
                  LastE     <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            AVG_SEQ: begin
               ChannelE <= ChannelE + CH_W'(1);
               if (cnt == '0) begin
                  RegWriteE <= 1'b1;
                  LastE     <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic accept;
   logic trap_q;

   assign accept = InstrValidD & ~StallD & ~FlushE;

   // Sticky record that an illegal instruction was issued
   always_ff @(posedge clk) begin
      if (reset) begin
         trap_q <= 1'b0;
      end else if (accept && dec.illegal) begin
         trap_q <= 1'b1;
      end
   end

   assign IllegalTrap = trap_q;
`else
   assign IllegalTrap = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit_mc.sv
// Directed self-checking bench for ctrl_unit_mc with default parameters
// (MULT_LAT=3, NUM_CH=3).
module tb_ctrl_unit_mc;

   logic       clk = 1'b0;
   logic       reset;
   logic       InstrValidD;
   logic [5:0] funct;
   logic [1:0] opcode;
   logic       FlushE;
   logic       StallD;
   logic [1:0] RegSrcD;
   logic [1:0] ImmSrcD;
   logic       IllegalD;
   logic       ValidE;
   logic       ALUSrcE;
   logic [3:0] ALUControlE;
   logic       MemToRegE;
   logic       RegWriteE;
   logic       PlusOneE;
   logic       BranchE;
   logic [1:0] ChannelE;
   logic       LastE;
   logic       IllegalTrap;

   int unsigned nchk = 0;
   int unsigned nerr = 0;

`ifdef CTRL_ILLEGAL_TRAP_EN
   localparam logic TRAP_EXP = 1'b1;
`else
   localparam logic TRAP_EXP = 1'b0;
`endif

   localparam logic [5:0] F_ADD  = 6'b001000;
   localparam logic [5:0] F_MULT = 6'b000000;
   localparam logic [5:0] F_AVG  = 6'b010000;
   localparam logic [5:0] F_STR  = 6'b010100;
   localparam logic [5:0] F_LOAD = 6'b011000;
   localparam logic [5:0] F_ILL  = 6'b001100;

   ctrl_unit_mc #(.MULT_LAT(3), .NUM_CH(3), .ALU_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .InstrValidD (InstrValidD),
      .funct       (funct),
      .opcode      (opcode),
      .FlushE      (FlushE),
      .StallD      (StallD),
      .RegSrcD     (RegSrcD),
      .ImmSrcD     (ImmSrcD),
      .IllegalD    (IllegalD),
      .ValidE      (ValidE),
      .ALUSrcE     (ALUSrcE),
      .ALUControlE (ALUControlE),
      .MemToRegE   (MemToRegE),
      .RegWriteE   (RegWriteE),
      .PlusOneE    (PlusOneE),
      .BranchE     (BranchE),
      .ChannelE    (ChannelE),
      .LastE       (LastE),
      .IllegalTrap (IllegalTrap)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] f, input logic [1:0] op);
      InstrValidD = v;
      funct       = f;
      opcode      = op;
   endtask

   initial begin
      reset = 1'b1;
      FlushE = 1'b0;
      drive(1'b0, 6'b0, 2'b00);
      step();
      step();
      chk("rst_valid", ValidE, 0);
      chk("rst_alu", ALUControlE, 3);
      chk("rst_stall", StallD, 0);
      chk("rst_regw", RegWriteE, 0);
      chk("rst_last", LastE, 0);
      chk("rst_trap", IllegalTrap, 0);

      // ADD
      reset = 1'b0;
      drive(1'b1, F_ADD, 2'b00);
      #1;
      chk("add_illd", IllegalD, 0);
      chk("add_imm", ImmSrcD, 0);
      step();
      chk("add_valid", ValidE, 1);
      chk("add_alu", ALUControlE, 0);
      chk("add_regw", RegWriteE, 1);
      chk("add_last", LastE, 1);
      chk("add_stall", StallD, 0);
      chk("add_ch", ChannelE, 0);
      drive(1'b0, F_ADD, 2'b00);
      step();
      chk("idle_valid", ValidE, 0);

      // MULT, with an ADD held in D during the stall
      drive(1'b1, F_MULT, 2'b00);
      step();
      chk("mul1_valid", ValidE, 1);
      chk("mul1_alu", ALUControlE, 2);
      chk("mul1_regw", RegWriteE, 0);
      chk("mul1_last", LastE, 0);
      chk("mul1_stall", StallD, 1);
      drive(1'b1, F_ADD, 2'b00);
      step();
      chk("mul2_alu", ALUControlE, 2);
      chk("mul2_regw", RegWriteE, 0);
      chk("mul2_stall", StallD, 1);
      step();
      chk("mul3_alu", ALUControlE, 2);
      chk("mul3_regw", RegWriteE, 1);
      chk("mul3_last", LastE, 1);
      chk("mul3_stall", StallD, 0);
      step();
      chk("held_add_alu", ALUControlE, 0);
      chk("held_add_regw", RegWriteE, 1);
      drive(1'b0, F_ADD, 2'b00);
      step();
      chk("mul_end_valid", ValidE, 0);

      // AVERAGE over three channels
      drive(1'b1, F_AVG, 2'b00);
      step();
      chk("av0_ch", ChannelE, 0);
      chk("av0_alu", ALUControlE, 4);
      chk("av0_regw", RegWriteE, 0);
      chk("av0_stall", StallD, 1);
      drive(1'b0, F_ADD, 2'b00);
      step();
      chk("av1_ch", ChannelE, 1);
      chk("av1_last", LastE, 0);
      chk("av1_stall", StallD, 1);
      step();
      chk("av2_ch", ChannelE, 2);
      chk("av2_regw", RegWriteE, 1);
      chk("av2_last", LastE, 1);
      chk("av2_stall", StallD, 0);
      step();
      chk("av_end_valid", ValidE, 0);

      // Flush in the middle of AVERAGE
      drive(1'b1, F_AVG, 2'b00);
      step();
      drive(1'b0, F_ADD, 2'b00);
      step();
      chk("fl_ch1", ChannelE, 1);
      FlushE = 1'b1;
      step();
      chk("fl_valid", ValidE, 0);
      chk("fl_stall", StallD, 0);
      chk("fl_regw", RegWriteE, 0);
      FlushE = 1'b0;
      drive(1'b1, F_ADD, 2'b00);
      step();
      chk("fl_add_valid", ValidE, 1);
      chk("fl_add_alu", ALUControlE, 0);
      chk("fl_add_last", LastE, 1);

      // Flush drops an instruction presented in IDLE
      FlushE = 1'b1;
      step();
      chk("fl_drop_valid", ValidE, 0);
      FlushE = 1'b0;

      // STR and LOAD
      drive(1'b1, F_STR, 2'b01);
      #1;
      chk("str_imm", ImmSrcD, 1);
      step();
      chk("str_regw", RegWriteE, 0);
      chk("str_alusrc", ALUSrcE, 1);
      chk("str_alu", ALUControlE, 3);
      drive(1'b1, F_LOAD, 2'b01);
      step();
      chk("ld_mem", MemToRegE, 1);
      chk("ld_regw", RegWriteE, 1);

      // Illegal cmd 4'b0110
      drive(1'b1, F_ILL, 2'b00);
      #1;
      chk("ill_illd", IllegalD, 1);
      chk("ill_regsrc", RegSrcD, 0);
      chk("ill_imm", ImmSrcD, 0);
      step();
      chk("ill_valid", ValidE, 1);
      chk("ill_regw", RegWriteE, 0);
      chk("ill_alu", ALUControlE, 3);
      chk("ill_last", LastE, 1);
      chk("ill_trap", IllegalTrap, 32'(TRAP_EXP));
      drive(1'b0, F_ADD, 2'b00);
      #1;
      chk("noval_illd", IllegalD, 0);
      step();
      step();
      chk("ill_trap_sticky", IllegalTrap, 32'(TRAP_EXP));

      // Reset during MULT
      drive(1'b1, F_MULT, 2'b00);
      step();
      chk("rm_stall_pre", StallD, 1);
      drive(1'b0, F_ADD, 2'b00);
      reset = 1'b1;
      step();
      chk("rm_valid", ValidE, 0);
      chk("rm_alu", ALUControlE, 3);
      chk("rm_stall", StallD, 0);
      chk("rm_regw", RegWriteE, 0);
      chk("rm_trap", IllegalTrap, 0);
      reset = 1'b0;
      step();
      chk("rm_after_valid", ValidE, 0);
      chk("rm_after_stall", StallD, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
